// File: rtl/sseg_scan_ctrl.sv
`timescale 1ns/1ps
// sseg_scan_ctrl
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// A free-running scan counter selects one digit at a time. A short dark
// window at the start of each digit slot prevents ghosting.
// Writes land in a pending buffer. They reach the display buffer only at
// the frame end, when the counter is all-ones, so a frame never shows a
// mix of old and new digits.
// Optional build macro: SSEG_LZB_EN enables leading-zero blanking of
// digits 3..1.
module sseg_scan_ctrl #(
   parameter int REFRESH_BITS = 18,
   parameter int BLANK_CYC    = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [15:0] wr_data,
   input  logic [3:0]  dp_in,
   output logic        busy,
   output logic [3:0]  an,
   output logic [7:0]  sseg
);

   // Width of the within-slot part of the counter.
   localparam int SLOT_W = REFRESH_BITS - 2;
   localparam logic [SLOT_W-1:0] BLANK_V = SLOT_W'(BLANK_CYC);
   localparam logic [REFRESH_BITS-1:0] CNT_ONE = REFRESH_BITS'(1);

   // Update handshake: IDLE means nothing is waiting. PEND means a write
   // is waiting for the next frame end.
   typedef enum logic {
      ST_IDLE,
      ST_PEND
   } state_t;

   state_t state_reg;
   state_t state_next;

   logic [REFRESH_BITS-1:0] cnt_reg;
   logic                    frame_end;
   logic                    commit;

   logic [15:0] pend_data_reg;
   logic [3:0]  pend_dp_reg;
   logic [15:0] disp_data_reg;
   logic [3:0]  disp_dp_reg;

   logic [1:0]        sel;
   logic [SLOT_W-1:0] slot;
   logic              blank;
   logic [3:0]        nib;
   logic [3:0]        dark;

   logic [3:0] an_next;
   logic [3:0] an_reg;
   logic [7:0] sseg_next;
   logic [7:0] sseg_reg;

   // Active-low hex glyphs, bit order a,b,c,d,e,f,g (a is the MSB).
   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      logic [6:0] g;
      case (n)
         4'h0:    g = 7'b0000001;
         4'h1:    g = 7'b1001111;
         4'h2:    g = 7'b0010010;
         4'h3:    g = 7'b0000110;
         4'h4:    g = 7'b1001100;
         4'h5:    g = 7'b0100100;
         4'h6:    g = 7'b0100000;
         4'h7:    g = 7'b0001111;
         4'h8:    g = 7'b0000000;
         4'h9:    g = 7'b0000100;
         4'hA:    g = 7'b0000010;
         4'hB:    g = 7'b1100000;
         4'hC:    g = 7'b0110001;
         4'hD:    g = 7'b1000010;
         4'hE:    g = 7'b0110000;
         default: g = 7'b0111000;
      endcase
      return g;
   endfunction

   // Free-running scan counter. It wraps naturally from all-ones to zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + CNT_ONE;
      end
   end

   assign frame_end = &cnt_reg;

   // Handshake state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic.
   // A write that arrives in the frame-end cycle stays pending while the
   // older pending value is committed in that same cycle.
   always_comb begin
      state_next = state_reg;
      commit     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (wr_en) begin
               state_next = ST_PEND;
            end
         end
         ST_PEND: begin
            if (frame_end) begin
               commit = 1'b1;
               if (!wr_en) begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign busy = (state_reg == ST_PEND);

   // Pending and display buffers.
   // A new write overwrites the pending buffer, so the last write wins.
   // The commit reads the pending value from before this edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_data_reg <= '0;
         pend_dp_reg   <= '0;
         disp_data_reg <= '0;
         disp_dp_reg   <= '0;
      end else begin
         if (wr_en) begin
            pend_data_reg <= wr_data;
            pend_dp_reg   <= dp_in;
         end
         if (commit) begin
            disp_data_reg <= pend_data_reg;
            disp_dp_reg   <= pend_dp_reg;
         end
      end
   end

   // Digit select and the dark window at the start of each slot.
   assign sel   = cnt_reg[REFRESH_BITS-1 -: 2];
   assign slot  = cnt_reg[SLOT_W-1:0];
   assign blank = (slot < BLANK_V);
   assign nib   = disp_data_reg[{sel, 2'b00} +: 4];

   // Per-digit dark flags.
   // Digit 0 is always shown so that a zero value is still visible.
   assign dark[0] = 1'b0;

   genvar gi;
   generate
      for (gi = 1; gi < 4; gi++) begin : g_lzb
`ifdef SSEG_LZB_EN
         // A digit is dark when it and every digit to its left are zero
         // and its own decimal point is off.
         assign dark[gi] = (disp_data_reg[15:4*gi] == '0) && !disp_dp_reg[gi];
`else
         assign dark[gi] = 1'b0;
`endif
      end

      // One anode per digit. It is low only for the selected digit,
      // outside the dark window, and when the digit is not blanked.
      for (gi = 0; gi < 4; gi++) begin : g_anode
         assign an_next[gi] = !((sel == 2'(gi)) && !blank && !dark[gi]);
      end
   endgenerate

   assign sseg_next = {~disp_dp_reg[sel], hex_glyph(nib)};

   // Output registers. They give one cycle of latency from the counter
   // value to the pins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an_reg   <= 4'b1111;
         sseg_reg <= 8'hFF;
      end else begin
         an_reg   <= an_next;
         sseg_reg <= sseg_next;
      end
   end

   assign an   = an_reg;
   assign sseg = sseg_reg;

endmodule

// File: doc/sseg_scan_ctrl.md
SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter REFRESH_BITS, default 18, SHALL set the scan counter width; each digit slot lasts 2^(REFRESH_BITS-2) cycles.
REQ-003 Parameter BLANK_CYC, default 256, SHALL set the inter-digit blanking cycles; legal range 0 to 2^(REFRESH_BITS-2)-1.
REQ-004 Port clk, input, 1, SHALL be the system clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1, SHALL be the asynchronous, active-high reset.
REQ-006 Port wr_en, input, 1, SHALL request a display update with the values on wr_data and dp_in, sampled in that cycle.
REQ-007 Port wr_data, input, 16, SHALL carry four hex digits; [3:0] is digit 0 (rightmost) and [15:12] is digit 3.
REQ-008 Port dp_in, input, 4, SHALL carry the decimal points; bit i lights digit i's point when 1.
REQ-009 Port busy, output, 1, SHALL be high while an accepted write is pending and not yet committed to the display.
REQ-010 Port an, output, 4, SHALL be the active-low digit anodes; bit i drives digit i.
REQ-011 Port sseg, output, 8, SHALL be the active-low segments in order dp,a,b,c,d,e,f,g (bit7 = dp, bit6 = a ... bit0 = g).

Function
REQ-012 The scan counter SHALL increment by 1 every cycle and wrap from all-ones to 0.
REQ-013 The digit index SHALL be the counter's top 2 bits, scanning 0,1,2,3 in order.
REQ-014 an SHALL be 4'b1111 whenever the counter's low REFRESH_BITS-2 bits are < BLANK_CYC; otherwise exactly the selected digit's bit SHALL be 0.
REQ-015 sseg[6:0] SHALL use the standard active-low hex glyphs for the selected nibble, e.g. 0=0000001, 1=1001111, 8=0000000, A=0000010, F=0111000.
REQ-016 sseg[7] SHALL be the inverse of the selected digit's committed dp bit.
REQ-017 an and sseg SHALL be registered, with 1 cycle latency from the counter value to the outputs.
REQ-018 wr_en=1 SHALL load wr_data and dp_in into the pending register and set busy=1 on the next edge.
REQ-019 When the counter equals all-ones (frame end), a pending value SHALL be copied to the display register and busy SHALL clear, so frames never tear.
REQ-020 A wr_en while busy=1 SHALL overwrite the pending value, so the last write wins; no write is ever refused.
REQ-021 A wr_en in the frame-end cycle SHALL NOT be committed in that cycle: the old pending value commits, the new value becomes pending, and busy stays 1.
REQ-022 wr_en at frame end with nothing pending SHALL only load the pending register, setting busy=1.

Reset
REQ-023 Reset assertion SHALL immediately force counter=0, display and pending registers=0, busy=0, an=4'b1111 and sseg=8'hFF.
REQ-024 Reset asserted mid-frame or mid-write SHALL discard any pending write.
REQ-025 After reset release, scanning SHALL restart at digit 0 with a blanking window.

Configuration
REQ-026 With macro SSEG_LZB_EN defined, leading-zero blanking SHALL apply: digit k (k=3..1) is held dark (an bit 1) when committed nibbles k..3 are all 0 and dp bit k is 0.
REQ-027 With SSEG_LZB_EN defined, digit 0 SHALL never be blanked.
REQ-028 Without SSEG_LZB_EN, all four digits SHALL always be driven, leading zeros included.

Verification (REFRESH_BITS=6, BLANK_CYC=2)
REQ-029 Reset pulse mid-scan -> an=1111, sseg=FF and busy=0 immediately; digit 0 lights 3 cycles after release (2 blank cycles plus 1 latency).
REQ-030 Write 16'h12AF, dp_in=4'b0100, then run 2 frames -> busy drops at frame end; in the next frame digit 0 shows F, digit 1 A, digit 2 "2" with sseg[7]=0, and digit 3 "1".
REQ-031 Two writes within one frame, 16'h1111 then 16'h2222 -> only 2222 is ever displayed; busy is 1 from the first write to frame end.
REQ-032 Write 16'h3333 asserted exactly at counter=63 -> the prior pending value commits, busy stays 1, and 3333 commits at the next frame end.
REQ-033 With SSEG_LZB_EN, write 16'h0005 -> an bits 3..1 stay 1 all frame and digit 0 shows 5; without the macro, digits 3..1 show 0.
REQ-034 Monitor over 4 frames -> an is never 1111 outside blank windows, at most one an bit is 0 at any time, and every blank window is exactly 2 cycles.
